// File: rtl/gem_frame_tx.sv
// GEM link framer: one K-char separator (BC,F7,FB,FD cycle; FC on overflow) then FRAME_BYTES-1 payload bytes, MSB first.
// Outputs registered from next-state, one cycle after capture; payload_ready is the combinational capture strobe.
module gem_frame_tx #(
  parameter int         FRAME_BYTES = 10,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic                         clock,
  input  logic                         global_reset_n,
  input  logic                         enable,
  input  logic                         ttc_resync,
  input  logic [(FRAME_BYTES-1)*8-1:0] payload,
  input  logic                         payload_valid,
  input  logic                         overflow,
  output logic                         payload_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_kchar,
  output logic                         frame_start,
  output logic [15:0]                  frame_cnt,
  output logic [15:0]                  underrun_cnt
);
  localparam int            PW       = (FRAME_BYTES-1)*8;
  localparam int            IW       = $clog2(FRAME_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES-1);
  localparam logic [7:0]    K_BC = 8'hBC;
  localparam logic [7:0]    K_F7 = 8'hF7;
  localparam logic [7:0]    K_FB = 8'hFB;
  localparam logic [7:0]    K_FD = 8'hFD;
  localparam logic [7:0]    K_FC = 8'hFC;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [1:0]    r_seq, w_seq_nxt, w_sep_seq;
  logic          r_pend, w_pend_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic [PW-1:0] r_shift, w_shift_nxt;
  logic [7:0]    r_tx_data, w_data_nxt;
  logic          r_tx_kchar, w_kchar_nxt;
  logic          r_frame_start, w_fs_nxt;
  logic [15:0]   r_frame_cnt, w_fcnt_nxt;
  logic [15:0]   r_underrun_cnt, w_ucnt_nxt;
  logic          w_capture;

  assign w_capture     = enable && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_RUN) && (r_idx == LAST_IDX)));
  assign payload_ready = w_capture;

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_seq          <= 2'd0;
      r_pend         <= 1'b0;
      r_ovf          <= 1'b0;
      r_shift        <= '0;
      r_tx_data      <= K_BC;
      r_tx_kchar     <= 1'b1;
      r_frame_start  <= 1'b0;
      r_frame_cnt    <= 16'd0;
      r_underrun_cnt <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_seq          <= w_seq_nxt;
      r_pend         <= w_pend_nxt;
      r_ovf          <= w_ovf_nxt;
      r_shift        <= w_shift_nxt;
      r_tx_data      <= w_data_nxt;
      r_tx_kchar     <= w_kchar_nxt;
      r_frame_start  <= w_fs_nxt;
      r_frame_cnt    <= w_fcnt_nxt;
      r_underrun_cnt <= w_ucnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_seq_nxt   = r_seq;
    w_sep_seq   = r_seq;
    w_pend_nxt  = r_pend | ttc_resync;
    w_ovf_nxt   = r_ovf;
    w_shift_nxt = r_shift;
    w_data_nxt  = K_BC;
    w_kchar_nxt = 1'b1;
    w_fs_nxt    = 1'b0;
    w_fcnt_nxt  = r_frame_cnt;
    w_ucnt_nxt  = r_underrun_cnt;
    if (w_capture) begin
      w_state_nxt = ST_RUN;
      w_idx_nxt   = '0;
      w_pend_nxt  = 1'b0;
      if (payload_valid) begin
        w_shift_nxt = payload;
        w_ovf_nxt   = overflow;
      end else begin
        w_shift_nxt = {(FRAME_BYTES-1){IDLE_BYTE}};
        w_ovf_nxt   = 1'b0;
        if (r_underrun_cnt != 16'hFFFF) w_ucnt_nxt = r_underrun_cnt + 16'd1;
      end
      // A resync arriving on the capture cycle itself still restarts this frame at BC.
      if (r_pend || ttc_resync) w_sep_seq = 2'd0;
      w_seq_nxt  = w_sep_seq + 2'd1;
      w_fs_nxt   = 1'b1;
      w_fcnt_nxt = r_frame_cnt + 16'd1;
      if (w_ovf_nxt) begin
        w_data_nxt = K_FC;
      end else begin
        case (w_sep_seq)
          2'd0:    w_data_nxt = K_BC;
          2'd1:    w_data_nxt = K_F7;
          2'd2:    w_data_nxt = K_FB;
          default: w_data_nxt = K_FD;
        endcase
      end
    end else if (r_state == ST_RUN) begin
      if (r_idx == LAST_IDX) begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt   = r_idx + IW'(1);
        w_data_nxt  = r_shift[PW-1 -: 8];
        w_kchar_nxt = 1'b0;
        w_shift_nxt = r_shift << 8;
      end
    end
  end

  assign tx_data      = r_tx_data;
  assign tx_kchar     = r_tx_kchar;
  assign frame_start  = r_frame_start;
  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_underrun_cnt;
endmodule
